// File: rtl/fetch_unit.sv
// Instruction fetch stage: a single-entry fetch buffer between instruction memory and decode.
// Optional define FETCH_ALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_success,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_instr_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] target_d;
  logic [31:0] pc_inc_d;
  logic        target_bad;
  logic        halt;

  assign pc_inc_d = pc_q + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target_d   = br_target;
  assign target_bad = |br_target[1:0];
  assign halt       = misalign_q;
  assign misalign   = misalign_q;

  // Once a bad target is seen the core stays parked until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_q <= 1'b0;
    end else if (br_success && (state_q != IDLE) && target_bad) begin
      misalign_q <= 1'b1;
    end
  end
`else
  logic unused_tgt_lsb;

  assign unused_tgt_lsb = ^br_target[1:0];
  assign target_d       = {br_target[31:2], 2'b00};
  assign target_bad     = 1'b0;
  assign halt           = 1'b0;
  assign misalign       = 1'b0;
`endif

  // Redirects win over both memory data and stall in every active state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      if_pc_q    <= 32'h0;
      if_instr_q <= NOP;
    end else begin
      case (state_q)
        IDLE: begin
          if (!halt) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ, HOLD: begin
          if (br_success) begin
            valid_q <= 1'b0;
            if (target_bad) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
            end else begin
              pc_q    <= target_d;
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end else if (state_q == REQ) begin
            if (imem_ready) begin
              if_instr_q <= imem_rdata;
              if_pc_q    <= pc_q;
              valid_q    <= 1'b1;
              pc_q       <= pc_inc_d;
              state_q    <= HOLD;
              req_q      <= 1'b0;
            end
          end else if (!stall) begin
            valid_q <= 1'b0;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign if_valid  = valid_q;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule
